code_ram_loader: RTL

Boot-time writer for the instruction memory. It receives a byte stream (from the UART receiver), packs little-endian bytes into 32-bit words, and drives the write port of the code RAM. It fills, one word per address, the same 10-bit word-addressed array that the fetch path reads through its `addr[11:2]` ROM port. While loading, it holds the CPU in reset via `busy`.

---
 rtl/loader_pkg.sv | 18 +
 rtl/code_ram_loader_byte_packer.sv | 59 +++++
 rtl/code_ram_loader.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared types and defaults for the code RAM boot loader.
// Included by code_ram_loader and byte_packer.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
    CSUM,
    FIN
  } state_t;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_LEN_W  = 16;
  localparam int BYTE_LANES = 4;

endpackage

// File: rtl/code_ram_loader_byte_packer.sv
// Packs little-endian bytes into 32-bit words; word_o/word_done_o register one cycle after the 4th byte.
// No backpressure of its own: the loader only pushes bytes it has accepted.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        push_i,
  input  logic [7:0]  byte_i,
  output logic        lane_last_o,
  output logic [31:0] word_o,
  output logic        word_done_o
);

  logic [23:0] shift_q, shift_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] word_q, word_d;
  logic        done_q, done_d;

  assign lane_last_o = (lane_q == 2'(BYTE_LANES - 1));
  assign word_o      = word_q;
  assign word_done_o = done_q;

  always_comb begin
    shift_d = shift_q;
    lane_d  = lane_q;
    word_d  = word_q;
    done_d  = 1'b0;
    if (clr_i) begin
      shift_d = '0;
      lane_d  = '0;
    end else if (push_i) begin
      lane_d = lane_q + 2'd1;
      if (lane_last_o) begin
        // Completed word leaves the shifter; wr_data holds until the next word.
        word_d = {byte_i, shift_q};
        done_d = 1'b1;
      end else begin
        shift_d = {byte_i, shift_q[23:8]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      lane_q  <= '0;
      word_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      lane_q  <= lane_d;
      word_q  <= word_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: rtl/code_ram_loader.sv
// Boot loader: byte stream (count, words, optional checksum) into code RAM writes; holds CPU via busy.
// Write lands one cycle after a word's 4th byte; rx_ready high only while collecting bytes.
// LOADER_CHECKSUM_EN adds a trailing 8-bit zero-sum checksum byte and the CSUM state.
module code_ram_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              m_clock,
  input  logic              p_reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  words_q, words_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              pend_q, pend_d;
  logic [LEN_W-1:0]  hdr_n;
  logic              accept;
  logic              pk_clr;
  logic              pk_push;
  logic              lane_last;
  logic              word_done;
  logic [31:0]       word;
  state_t            after_body;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  assign after_body = CSUM;
`else
  assign after_body = FIN;
`endif

  assign rx_ready = (state_q == LEN0) || (state_q == LEN1) ||
                    (state_q == DATA) || (state_q == CSUM);
  assign accept   = rx_valid && rx_ready;
  assign hdr_n    = LEN_W'({rx_data, len_q[7:0]});
  assign pk_push  = accept && (state_q == DATA);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    words_d = words_q;
    addr_d  = addr_q;
    done_d  = done_q;
    err_d   = err_q;
    pend_d  = pend_q;
    pk_clr  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    sum_d = sum_q;
    if (accept) sum_d = sum_q + rx_data;
`endif
    if (word_done) addr_d = addr_q + ADDR_W'(1);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LEN0;
          words_d = '0;
          addr_d  = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          pend_d  = 1'b0;
          pk_clr  = 1'b1;
`ifdef LOADER_CHECKSUM_EN
          sum_d = '0;
`endif
        end
      end
      LEN0: begin
        if (accept) begin
          len_d   = '0;
          len_d[7:0] = rx_data;
          state_d = LEN1;
        end
      end
      LEN1: begin
        if (accept) begin
          len_d = hdr_n;
          if (hdr_n == '0) begin
            state_d = after_body;
          end else if (32'(hdr_n) > DEPTH) begin
            // Oversized image: leave the rest of the stream unread.
            pend_d  = 1'b1;
            state_d = FIN;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (pk_push && lane_last) begin
          words_d = words_q + LEN_W'(1);
          if (words_d == len_q) state_d = after_body;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CSUM: begin
        if (accept) begin
          pend_d  = (sum_d != 8'h00);
          state_d = FIN;
        end
      end
`endif
      FIN: begin
        done_d  = 1'b1;
        err_d   = pend_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      words_q <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      words_q <= words_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) sum_q <= '0;
    else          sum_q <= sum_d;
  end
`endif

  byte_packer u_packer (
    .clk         (m_clock),
    .rst_n       (p_reset),
    .clr_i       (pk_clr),
    .push_i      (pk_push),
    .byte_i      (rx_data),
    .lane_last_o (lane_last),
    .word_o      (word),
    .word_done_o (word_done)
  );

  assign wr_en   = word_done;
  assign wr_addr = addr_q;
  assign wr_data = word;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign err     = err_q;

endmodule
